thermocouple_scanner: RTL and testbench
=======================================

# thermocouple_scanner

Multi-channel successor to the single-channel thermocouple reader. The scanner round-robin polls up to NUM_CH MAX31855-style converters through the shared SPI master, one 32-bit frame per channel. For each channel it holds the last good thermocouple temperature, junction temperature and fault bits. It adds a channel-enable mask, a busy-timeout, consecutive-fault counting with a per-channel failed flag, and a sweep-complete strobe for the telemetry logic.

## Interface
Parameters:
- NUM_CH, 4: number of converters (1..16).
- STARTUP_CYC, 72000: converter power-up wait after reset (3 s at 24 kHz).
- GAP_CYC, 24000: idle cycles between consecutive frames.
- TIMEOUT_CYC, 1024: maximum cycles spent waiting on a busy edge.
- FAULT_LIMIT, 3: consecutive faulty frames before a channel is marked failed (1..15).

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- ch_enable, in, NUM_CH: per-channel poll enable. Sampled at each channel selection.
- spi_not_busy, in, 1: SPI master idle.
- spi_rx_data, in, 32: last received frame. Valid while spi_not_busy=1 after a transfer.
- spi_ena, out, 1: SPI transfer request.
- spi_cs_sel, out, CH_W: converter select. CH_W = max(1, clog2(NUM_CH)).
- tc_temp_data, out, 14*NUM_CH: channel i occupies bits [14i+13:14i].
- junction_temp_data, out, 12*NUM_CH: channel i occupies bits [12i+11:12i].
- fault_bits, out, 4*NUM_CH: per channel {timeout_or_D16, D2, D1, D0}.
- data_valid, out, NUM_CH: at least one good frame captured since reset.
- ch_failed, out, NUM_CH: fault count has reached FAULT_LIMIT.
- sweep_done, out, 1: one-cycle pulse when the scan wraps.

## Operation
- Reset value of every output and register is 0, including spi_cs_sel. The state returns to STARTUP.
- States: STARTUP, SELECT, REQUEST, WAIT_DONE, CAPTURE, GAP.
- STARTUP:
  - Lasts exactly STARTUP_CYC cycles after rst falls.
  - Then moves to SELECT with channel pointer 0.
- SELECT:
  - Searches from the pointer for the first enabled channel, wrapping modulo NUM_CH.
  - Drives spi_cs_sel to that channel and moves to REQUEST.
  - If ch_enable is all zero, stays in SELECT with spi_ena=0.
  - Crossing from the highest index back to a lower one pulses sweep_done.
- REQUEST:
  - spi_ena=1 while spi_not_busy=1.
  - On spi_not_busy=0, clears spi_ena and moves to WAIT_DONE.
- WAIT_DONE: waits for spi_not_busy=1, then moves to CAPTURE.
- Timeout:
  - The timeout counter runs across REQUEST plus WAIT_DONE.
  - On reaching TIMEOUT_CYC, the transaction is treated as a faulty frame: fault_bits = 4'b1000, temperatures untouched, spi_ena cleared.
  - The state then moves to GAP.
- CAPTURE (1 cycle):
  - Good frame (bit16=0):
    - tc_temp <= rx[31:18]; junction <= rx[15:4]; fault <= {1'b0, rx[2:0]}.
    - data_valid set; fault counter cleared; ch_failed cleared.
  - Faulty frame (bit16=1):
    - Temperatures hold their last value. Junction is still updated from rx[15:4].
    - fault <= {1'b1, rx[2:0]}.
    - Fault counter saturating-increments. ch_failed is set when the counter reaches FAULT_LIMIT.
- GAP:
  - Counts GAP_CYC cycles.
  - Then advances the pointer by 1 (modulo NUM_CH) and moves to SELECT.
- Illegal state encoding recovers to SELECT.
- Only the selected channel's fields change. All other channels hold.
- Disabling a channel keeps its last data. A channel disabled mid-transaction completes that transaction.

## Timing
- spi_ena rises on the first cycle in REQUEST, i.e. the cycle after SELECT. cs_sel is stable from SELECT through GAP.
- Captured data is visible the cycle after CAPTURE.
- Frame-to-frame spacing is at least GAP_CYC+4 cycles.
- Asserting rst in any state aborts the transaction on the next edge: spi_ena=0 and all outputs return to 0.
- Simultaneous timeout and spi_not_busy rise: timeout wins, the frame is discarded.
- sweep_done is asserted for exactly one cycle per wrap. It never fires when only one channel is enabled and the pointer does not wrap through a lower index.
  - With NUM_CH=1, it pulses every frame.

## Structure
- Package thermocouple_pkg holds:
  - the state enum;
  - frame field localparams: TC_MSB/LSB 31:18, FAULT_BIT 16, JT_MSB/LSB 15:4, FLAG_MSB 2;
  - a frame_t struct.
- Sub-module tc_channel_regs (one instance per channel) holds that channel's temperatures, fault bits, valid flag, fault counter and failed flag. Its inputs are a capture strobe, a timeout strobe and the frame.
- The top level contains the scan FSM, counters and pointer.

## Test plan
- STARTUP_CYC=10, all channels enabled, BFM returns 0x1900_1910 → spi_ena first rises at cycle 11. Channel 0 tc=0x0640, jt=0x191, fault=0, data_valid[0]=1.
- ch_enable=4'b1010 → spi_cs_sel sequence 1,3,1,3. sweep_done pulses after each channel-3 GAP.
- Channel 2 returns bit16=1 with rx[2:0]=3'b001 three times, FAULT_LIMIT=3:
  - tc_temp_data[2] holds its prior value; fault=4'b1001;
  - ch_failed[2] rises after the third frame;
  - the next good frame clears it.
- BFM never drops spi_not_busy, TIMEOUT_CYC=16 → spi_ena drops after 16 cycles, fault_bits=4'b1000, pointer advances.
- ch_enable=0 → spi_ena stays 0 indefinitely. Setting bit 0 starts a transfer within 2 cycles.
- rst pulsed during WAIT_DONE → next cycle all outputs are 0. STARTUP restarts.

Source files
------------

// File: rtl/thermocouple_scanner_pkg.sv
// Shared types and MAX31855 frame layout for the multi-channel thermocouple scanner.
package thermocouple_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_SELECT    = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    localparam int TC_MSB    = 31;
    localparam int TC_LSB    = 18;
    localparam int FAULT_BIT = 16;
    localparam int JT_MSB    = 15;
    localparam int JT_LSB    = 4;
    localparam int FLAG_MSB  = 2;

    typedef struct packed {
        logic [13:0] tc;
        logic        fault;
        logic [11:0] jt;
        logic [2:0]  flags;
    } frame_t;

endpackage

// File: rtl/thermocouple_scanner_tc_channel_regs.sv
// Per-channel result storage: last good temperatures, fault flags and consecutive-fault tracking.
module tc_channel_regs
    import thermocouple_pkg::*;
#(
    parameter int FAULT_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_i,
    input  logic        tmo_i,
    input  frame_t      frame_i,
    output logic [13:0] tc_o,
    output logic [11:0] jt_o,
    output logic [3:0]  fault_o,
    output logic        valid_o,
    output logic        failed_o
);

    logic [13:0] tc_q, tc_d;
    logic [11:0] jt_q, jt_d;
    logic [3:0]  fault_q, fault_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        failed_q, failed_d;

    always_comb begin
        tc_d     = tc_q;
        jt_d     = jt_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        failed_d = failed_q;
        if (cap_i && !frame_i.fault) begin
            tc_d     = frame_i.tc;
            jt_d     = frame_i.jt;
            fault_d  = {1'b0, frame_i.flags};
            valid_d  = 1'b1;
            cnt_d    = '0;
            failed_d = 1'b0;
        end else if (tmo_i || cap_i) begin
            // Faulty frame still carries a valid cold-junction reading; a timeout carries nothing.
            if (cap_i) begin
                jt_d = frame_i.jt;
            end
            fault_d = tmo_i ? 4'b1000 : {1'b1, frame_i.flags};
            if (cnt_q != 4'(FAULT_LIMIT)) begin
                cnt_d = cnt_q + 4'd1;
            end
            failed_d = failed_q | (cnt_d == 4'(FAULT_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q     <= '0;
            jt_q     <= '0;
            fault_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            tc_q     <= tc_d;
            jt_q     <= jt_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            failed_q <= failed_d;
        end
    end

    assign tc_o     = tc_q;
    assign jt_o     = jt_q;
    assign fault_o  = fault_q;
    assign valid_o  = valid_q;
    assign failed_o = failed_q;

endmodule

// File: rtl/thermocouple_scanner.sv
// Round-robin scanner polling NUM_CH thermocouple converters through one shared SPI master.
module thermocouple_scanner
    import thermocouple_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int STARTUP_CYC = 72000,
    parameter int GAP_CYC     = 24000,
    parameter int TIMEOUT_CYC = 1024,
    parameter int FAULT_LIMIT = 3,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 spi_not_busy,
    input  logic [31:0]          spi_rx_data,
    output logic                 spi_ena,
    output logic [CH_W-1:0]      spi_cs_sel,
    output logic [14*NUM_CH-1:0] tc_temp_data,
    output logic [12*NUM_CH-1:0] junction_temp_data,
    output logic [4*NUM_CH-1:0]  fault_bits,
    output logic [NUM_CH-1:0]    data_valid,
    output logic [NUM_CH-1:0]    ch_failed,
    output logic                 sweep_done
);

    state_t          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] cs_q, cs_d;
    logic            sweep_q, sweep_d;
    logic            cap, tmo;
    logic            found;
    logic [CH_W-1:0] sel_idx;
    frame_t          frame;
    logic            unused_rsvd;

    assign frame = '{tc:    spi_rx_data[TC_MSB:TC_LSB],
                     fault: spi_rx_data[FAULT_BIT],
                     jt:    spi_rx_data[JT_MSB:JT_LSB],
                     flags: spi_rx_data[FLAG_MSB:0]};
    // Reserved frame bits (17 = always 0, 3 = reserved).
    assign unused_rsvd = ^{spi_rx_data[17], spi_rx_data[3]};

    always_comb begin
        int unsigned j;
        found   = 1'b0;
        sel_idx = '0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            j = (32'(ptr_q) + k) % NUM_CH;
            if (!found && ch_enable[j]) begin
                found   = 1'b1;
                sel_idx = CH_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cs_d    = cs_q;
        sweep_d = 1'b0;
        cap     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == 32'(STARTUP_CYC - 1)) begin
                    state_d = ST_SELECT;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SELECT: begin
                if (found) begin
                    state_d = ST_REQUEST;
                    cs_d    = sel_idx;
                    ptr_d   = sel_idx;
                    cnt_d   = '0;
                    sweep_d = (sel_idx < ptr_q);
                end
            end
            ST_REQUEST, ST_WAIT_DONE: begin
                // Timeout is checked first so it wins over a simultaneous not-busy rise.
                if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                    tmo     = 1'b1;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (state_q == ST_REQUEST && !spi_not_busy) begin
                        state_d = ST_WAIT_DONE;
                    end else if (state_q == ST_WAIT_DONE && spi_not_busy) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                cap     = 1'b1;
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: begin
                if (cnt_q == 32'(GAP_CYC - 1)) begin
                    state_d = ST_SELECT;
                    cnt_d   = '0;
                    sweep_d = (ptr_q == CH_W'(NUM_CH - 1));
                    ptr_d   = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_SELECT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STARTUP;
            cnt_q   <= '0;
            ptr_q   <= '0;
            cs_q    <= '0;
            sweep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cs_q    <= cs_d;
            sweep_q <= sweep_d;
        end
    end

    assign spi_ena    = (state_q == ST_REQUEST) && spi_not_busy;
    assign spi_cs_sel = cs_q;
    assign sweep_done = sweep_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = (cs_q == CH_W'(i));
        tc_channel_regs #(.FAULT_LIMIT(FAULT_LIMIT)) u_regs (
            .clk      (clk),
            .rst      (rst),
            .cap_i    (cap & sel),
            .tmo_i    (tmo & sel),
            .frame_i  (frame),
            .tc_o     (tc_temp_data[14*i +: 14]),
            .jt_o     (junction_temp_data[12*i +: 12]),
            .fault_o  (fault_bits[4*i +: 4]),
            .valid_o  (data_valid[i]),
            .failed_o (ch_failed[i])
        );
    end

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Directed self-checking bench for thermocouple_scanner with a simple SPI master model.
module tb_thermocouple_scanner;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_enable;
    logic                 spi_not_busy;
    logic [31:0]          spi_rx_data;
    logic                 spi_ena;
    logic [CH_W-1:0]      spi_cs_sel;
    logic [14*NUM_CH-1:0] tc_temp_data;
    logic [12*NUM_CH-1:0] junction_temp_data;
    logic [4*NUM_CH-1:0]  fault_bits;
    logic [NUM_CH-1:0]    data_valid;
    logic [NUM_CH-1:0]    ch_failed;
    logic                 sweep_done;

    logic [31:0] rx_tab [NUM_CH];
    bit          hang;
    int          n_checks = 0;
    int          n_pass   = 0;

    thermocouple_scanner #(
        .NUM_CH      (NUM_CH),
        .STARTUP_CYC (10),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (16),
        .FAULT_LIMIT (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ch_enable          (ch_enable),
        .spi_not_busy       (spi_not_busy),
        .spi_rx_data        (spi_rx_data),
        .spi_ena            (spi_ena),
        .spi_cs_sel         (spi_cs_sel),
        .tc_temp_data       (tc_temp_data),
        .junction_temp_data (junction_temp_data),
        .fault_bits         (fault_bits),
        .data_valid         (data_valid),
        .ch_failed          (ch_failed),
        .sweep_done         (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPI master model: busy for three cycles after a request, then presents the channel's frame.
    initial begin
        spi_not_busy = 1'b1;
        spi_rx_data  = '0;
        forever begin
            @(negedge clk);
            if (spi_ena && !hang) begin
                spi_not_busy = 1'b0;
                repeat (3) @(negedge clk);
                spi_rx_data  = rx_tab[spi_cs_sel];
                spi_not_busy = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ena(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (spi_ena) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_frame(output bit ok);
        wait_ena(ok);
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (spi_ena !== 1'b0) $display("FAIL reset_ena: got %b want 0", spi_ena); else n_pass++;
        n_checks++;
        if (spi_cs_sel !== '0) $display("FAIL reset_cs: got %h want 0", spi_cs_sel); else n_pass++;
        n_checks++;
        if (tc_temp_data !== '0) $display("FAIL reset_tc: got %h want 0", tc_temp_data); else n_pass++;
        n_checks++;
        if (junction_temp_data !== '0) $display("FAIL reset_jt: got %h want 0", junction_temp_data); else n_pass++;
        n_checks++;
        if (fault_bits !== '0) $display("FAIL reset_fault: got %h want 0", fault_bits); else n_pass++;
        n_checks++;
        if ({data_valid, ch_failed, sweep_done} !== '0)
            $display("FAIL reset_flags: got %h want 0", {data_valid, ch_failed, sweep_done});
        else n_pass++;
    endtask

    task automatic test_startup();
        int first = -1;
        bit v15 = 1'b1, v16 = 1'b0;
        logic [CH_W-1:0] cs0 = '1;
        ch_enable = 4'b1111;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (spi_ena && first < 0) begin
                first = c;
                cs0 = spi_cs_sel;
            end
            if (c == 15) v15 = data_valid[0];
            if (c == 16) v16 = data_valid[0];
            step();
        end
        n_checks++;
        if (first != 11) $display("FAIL startup_first_ena: got cycle %0d want 11", first); else n_pass++;
        n_checks++;
        if (cs0 !== 2'd0) $display("FAIL startup_cs: got %0d want 0", cs0); else n_pass++;
        n_checks++;
        if ({v15, v16} !== 2'b01) $display("FAIL startup_valid_timing: got %b want 01", {v15, v16}); else n_pass++;
        n_checks++;
        if (tc_temp_data[13:0] !== 14'h0640) $display("FAIL startup_tc0: got %h want 0640", tc_temp_data[13:0]); else n_pass++;
        n_checks++;
        if (junction_temp_data[11:0] !== 12'h191) $display("FAIL startup_jt0: got %h want 191", junction_temp_data[11:0]); else n_pass++;
        n_checks++;
        if (fault_bits[3:0] !== 4'h0) $display("FAIL startup_fault0: got %h want 0", fault_bits[3:0]); else n_pass++;
    endtask

    task automatic test_enable_mask();
        logic [CH_W-1:0] seq [4];
        int nr = 0, ns = 0;
        bit prev_e = 1'b0, prev_s = 1'b0, wide = 1'b0, cs_bad = 1'b0;
        ch_enable = 4'b1010;
        do_reset();
        for (int c = 0; c < 300 && !(nr == 4 && ns == 2); c++) begin
            if (spi_ena && !prev_e && nr < 4) begin
                seq[nr] = spi_cs_sel;
                nr++;
            end
            if (sweep_done) begin
                if (prev_s) wide = 1'b1;
                else ns++;
                if (spi_cs_sel !== 2'd3) cs_bad = 1'b1;
            end
            prev_e = spi_ena;
            prev_s = sweep_done;
            step();
        end
        n_checks++;
        if (nr != 4 || {seq[0], seq[1], seq[2], seq[3]} !== {2'd1, 2'd3, 2'd1, 2'd3})
            $display("FAIL mask_cs_seq: got %0d frames %0d,%0d,%0d,%0d want 1,3,1,3",
                     nr, seq[0], seq[1], seq[2], seq[3]);
        else n_pass++;
        n_checks++;
        if (ns != 2) $display("FAIL mask_sweep_count: got %0d want 2", ns); else n_pass++;
        n_checks++;
        if ({wide, cs_bad} !== 2'b00) $display("FAIL mask_sweep_shape: got wide=%b after_non3=%b want 0 0", wide, cs_bad); else n_pass++;
    endtask

    task automatic test_fault_count();
        bit ok;
        ch_enable  = 4'b0100;
        rx_tab[2]  = 32'h2AF0_0DE0;
        do_reset();
        do_frame(ok);
        n_checks++;
        if (!ok || tc_temp_data[41:28] !== 14'h0ABC || junction_temp_data[35:24] !== 12'h0DE || !data_valid[2])
            $display("FAIL fault_good_first: got ok=%b tc=%h jt=%h v=%b want 1 0abc 0de 1",
                     ok, tc_temp_data[41:28], junction_temp_data[35:24], data_valid[2]);
        else n_pass++;
        rx_tab[2] = 32'h7FFD_1231;
        do_frame(ok);
        n_checks++;
        if (!ok || tc_temp_data[41:28] !== 14'h0ABC || junction_temp_data[35:24] !== 12'h123)
            $display("FAIL fault1_temps: got ok=%b tc=%h jt=%h want 1 0abc 123",
                     ok, tc_temp_data[41:28], junction_temp_data[35:24]);
        else n_pass++;
        n_checks++;
        if (fault_bits[11:8] !== 4'b1001 || ch_failed[2] !== 1'b0)
            $display("FAIL fault1_flags: got fault=%b failed=%b want 1001 0", fault_bits[11:8], ch_failed[2]);
        else n_pass++;
        do_frame(ok);
        n_checks++;
        if (!ok || ch_failed[2] !== 1'b0) $display("FAIL fault2_failed: got ok=%b failed=%b want 1 0", ok, ch_failed[2]); else n_pass++;
        do_frame(ok);
        n_checks++;
        if (!ok || ch_failed !== 4'b0100) $display("FAIL fault3_failed: got ok=%b failed=%b want 1 0100", ok, ch_failed); else n_pass++;
        n_checks++;
        if (data_valid !== 4'b0100 || tc_temp_data[13:0] !== 14'h0)
            $display("FAIL fault_isolation: got valid=%b tc0=%h want 0100 0", data_valid, tc_temp_data[13:0]);
        else n_pass++;
        rx_tab[2] = 32'h2AF0_0DE0;
        do_frame(ok);
        n_checks++;
        if (!ok || ch_failed[2] !== 1'b0 || fault_bits[11:8] !== 4'b0000 || junction_temp_data[35:24] !== 12'h0DE)
            $display("FAIL fault_recover: got ok=%b failed=%b fault=%b jt=%h want 1 0 0000 0de",
                     ok, ch_failed[2], fault_bits[11:8], junction_temp_data[35:24]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int width = 0;
        ch_enable = 4'b0011;
        hang      = 1'b1;
        do_reset();
        wait_ena(ok);
        for (int c = 0; c < 40 && spi_ena; c++) begin
            width++;
            step();
        end
        n_checks++;
        if (!ok || width != 16) $display("FAIL timeout_ena_width: got ok=%b width=%0d want 1 16", ok, width); else n_pass++;
        n_checks++;
        if (fault_bits[3:0] !== 4'b1000 || tc_temp_data[13:0] !== 14'h0 || data_valid[0] !== 1'b0)
            $display("FAIL timeout_result: got fault=%b tc=%h valid=%b want 1000 0 0",
                     fault_bits[3:0], tc_temp_data[13:0], data_valid[0]);
        else n_pass++;
        wait_ena(ok);
        n_checks++;
        if (!ok || spi_cs_sel !== 2'd1) $display("FAIL timeout_advance: got ok=%b cs=%0d want 1 1", ok, spi_cs_sel); else n_pass++;
        hang = 1'b0;
    endtask

    task automatic test_all_disabled();
        bit seen = 1'b0;
        int lat = -1;
        ch_enable = 4'b0000;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            if (spi_ena) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen) $display("FAIL disabled_idle: got spi_ena=1 want 0"); else n_pass++;
        ch_enable = 4'b0001;
        for (int c = 1; c <= 2 && lat < 0; c++) begin
            step();
            if (spi_ena) lat = c;
        end
        n_checks++;
        if (lat < 0 || spi_cs_sel !== 2'd0) $display("FAIL disabled_wake: got latency=%0d cs=%0d want <=2 0", lat, spi_cs_sel); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, ok2;
        int first = -1;
        ch_enable = 4'b1111;
        do_reset();
        do_frame(ok);
        wait_ena(ok2);
        repeat (2) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (!ok || !ok2 || {spi_ena, spi_cs_sel, sweep_done, data_valid, ch_failed} !== '0)
            $display("FAIL midreset_ctrl: got ok=%b%b ena=%b cs=%0d sweep=%b valid=%b failed=%b want all 0",
                     ok, ok2, spi_ena, spi_cs_sel, sweep_done, data_valid, ch_failed);
        else n_pass++;
        n_checks++;
        if ({tc_temp_data, junction_temp_data, fault_bits} !== '0)
            $display("FAIL midreset_data: got tc=%h jt=%h fault=%h want 0", tc_temp_data, junction_temp_data, fault_bits);
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c <= 20 && first < 0; c++) begin
            if (spi_ena) first = c;
            step();
        end
        n_checks++;
        if (first != 11) $display("FAIL midreset_restart: got cycle %0d want 11", first); else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        hang      = 1'b0;
        ch_enable = 4'b1111;
        rx_tab[0] = 32'h1900_1910;
        rx_tab[1] = 32'h0C80_0A00;
        rx_tab[2] = 32'h2AF0_0DE0;
        rx_tab[3] = 32'h0640_0320;
        test_reset();
        test_startup();
        test_enable_mask();
        test_fault_count();
        test_timeout();
        test_all_disabled();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
